// File: rtl/slc3_mem_responder.sv
// ============================================================================
// Module      : slc3_mem_responder
// Description : Turns SLC-3 read/write strobes into timed asynchronous SRAM
//               cycles. Address 0xFFFF maps to the switches and the hex display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slc3_mem_responder #(
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Ready,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Data,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned c_MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int unsigned c_CNT_W    = $clog2(c_MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(READ_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST = c_CNT_W'(WRITE_WAIT - 1);
    localparam logic [19:0]        c_IO_ADDR = 20'h0FFFF;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_DONE  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_PULSE = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_IO_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rd_q;
    logic               r_wr_q;
    logic [19:0]        r_addr;
    logic [15:0]        r_wdata;
    logic               w_rd_edge;
    logic               w_wr_edge;
    logic               w_accept;
    logic               w_is_io;
    logic               w_in_wait;

    assign w_rd_edge = Mem_OE & ~r_rd_q;
    assign w_wr_edge = Mem_WE & ~r_wr_q;
    assign w_accept  = (r_state == S_IDLE) && (w_rd_edge || w_wr_edge);
    assign w_is_io   = (ADDR == c_IO_ADDR);
    assign w_in_wait = (r_state == S_RD_WAIT) || (r_state == S_WR_PULSE);

    assign SRAM_ADDR   = r_addr;
    assign SRAM_DQ_out = r_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state change, so each wait state starts at zero.
            if (w_next != r_state || !w_in_wait)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_q      <= 1'b0;
            r_wr_q      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            Data_to_CPU <= '0;
            HEX_Data    <= '0;
        end else begin
            r_rd_q <= Mem_OE;
            r_wr_q <= Mem_WE;
            if (w_accept) begin
                r_addr  <= ADDR;
                r_wdata <= Data_from_CPU;
                // A write edge wins over a simultaneous read edge.
                if (w_is_io) begin
                    if (w_wr_edge)
                        HEX_Data <= Data_from_CPU;
                    else
                        Data_to_CPU <= Switches;
                end
            end
            if (r_state == S_RD_WAIT && r_cnt == c_RD_LAST)
                Data_to_CPU <= SRAM_DQ_in;
        end
    end

    always_comb begin
        w_next     = r_state;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;
        Mem_Ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_edge)
                    w_next = w_is_io ? S_IO_DONE : S_WR_SETUP;
                else if (w_rd_edge)
                    w_next = w_is_io ? S_IO_DONE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (r_cnt == c_RD_LAST)
                    w_next = S_RD_DONE;
            end
            S_RD_DONE: begin
                Mem_Ready = 1'b1;
                w_next    = S_IDLE;
            end
            S_WR_SETUP: begin
                SRAM_CE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                w_next     = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                SRAM_CE_N  = 1'b0;
                SRAM_WE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                if (r_cnt == c_WR_LAST)
                    w_next = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                // Bus stays driven one cycle past WE_N rising to meet data hold.
                SRAM_CE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                Mem_Ready  = 1'b1;
                w_next     = S_IDLE;
            end
            S_IO_DONE: begin
                Mem_Ready = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_slc3_mem_responder.sv
// ============================================================================
// Module      : tb_slc3_mem_responder
// Description : Directed bench for slc3_mem_responder with a small SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slc3_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [19:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic [15:0] Switches;
    logic [15:0] HEX_Data;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    int vectors    = 0;
    int miscompares = 0;
    int we_low_cnt = 0;
    int ce_low_cnt = 0;
    int ready_cnt  = 0;

    logic [15:0] mem [0:63];

    always #5 Clk = ~Clk;

    slc3_mem_responder #(.READ_WAIT(2), .WRITE_WAIT(2)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
        .Switches(Switches), .HEX_Data(HEX_Data), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    // SRAM model: 64 words, reads combinational while selected, writes while WE_N low.
    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[5:0]] : 16'h5A5A;

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe)
            mem[SRAM_ADDR[5:0]] <= SRAM_DQ_out;
        if (!SRAM_WE_N) we_low_cnt <= we_low_cnt + 1;
        if (!SRAM_CE_N) ce_low_cnt <= ce_low_cnt + 1;
        if (Mem_Ready)  ready_cnt  <= ready_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = '0;
        Data_from_CPU = '0; Switches = '0;
        step(2);
        check("rst_ready", Mem_Ready, 0);
        check("rst_data", Data_to_CPU, 0);
        check("rst_hex", HEX_Data, 0);
        check("rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe}, 6'b111110);
        check("rst_addr", SRAM_ADDR, 0);
        check("rst_wdata", SRAM_DQ_out, 0);
        Reset = 1'b0;
        step(1);

        // SRAM write 0x1234 -> 0x00010
        we_low_cnt = 0; ready_cnt = 0;
        ADDR = 20'h00010; Data_from_CPU = 16'h1234; Mem_WE = 1'b1;
        step(1);
        Mem_WE = 1'b0;
        check("wr_setup_ctl", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_oe, SRAM_OE_N}, 4'b0111);
        check("wr_setup_addr", SRAM_ADDR, 20'h00010);
        check("wr_setup_dq", SRAM_DQ_out, 16'h1234);
        step(1);
        check("wr_pulse1_we", {SRAM_WE_N, SRAM_DQ_oe, Mem_Ready}, 3'b010);
        step(1);
        check("wr_pulse2_we", {SRAM_WE_N, SRAM_DQ_oe, Mem_Ready}, 3'b010);
        step(1);
        check("wr_hold", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_oe, Mem_Ready}, 4'b0111);
        check("wr_data_untouched", Data_to_CPU, 16'h0000);
        step(1);
        check("wr_idle", {SRAM_CE_N, SRAM_DQ_oe, Mem_Ready}, 3'b100);
        check("wr_we_low_cycles", we_low_cnt, 2);
        check("wr_ready_count", ready_cnt, 1);

        // SRAM read back 0x00010
        ADDR = 20'h00010; Data_from_CPU = 16'h0000; Mem_OE = 1'b1;
        step(1);
        Mem_OE = 1'b0;
        check("rd_wait_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe}, 4'b0010);
        step(1);
        check("rd_wait2_ready", Mem_Ready, 0);
        step(1);
        check("rd_ready", Mem_Ready, 1);
        check("rd_data", Data_to_CPU, 16'h1234);
        step(1);
        check("rd_ready_drop", Mem_Ready, 0);
        check("rd_data_hold", Data_to_CPU, 16'h1234);

        // I/O read of switches
        ce_low_cnt = 0;
        Switches = 16'hBEEF; ADDR = 20'h0FFFF; Mem_OE = 1'b1;
        step(1);
        Mem_OE = 1'b0;
        check("io_rd_ready", Mem_Ready, 1);
        check("io_rd_data", Data_to_CPU, 16'hBEEF);
        check("io_rd_ce", SRAM_CE_N, 1);
        step(1);
        check("io_rd_ready_drop", Mem_Ready, 0);
        check("io_rd_no_ce", ce_low_cnt, 0);

        // I/O write to hex display
        ce_low_cnt = 0; we_low_cnt = 0;
        ADDR = 20'h0FFFF; Data_from_CPU = 16'h00C5; Mem_WE = 1'b1;
        step(1);
        Mem_WE = 1'b0;
        check("io_wr_ready", Mem_Ready, 1);
        check("io_wr_hex", HEX_Data, 16'h00C5);
        check("io_wr_data_keep", Data_to_CPU, 16'hBEEF);
        step(1);
        check("io_wr_no_strobe", {ce_low_cnt[15:0], we_low_cnt[15:0]}, 32'h0);

        // SRAM read after I/O write leaves HEX_Data alone
        ADDR = 20'h00010; Data_from_CPU = 16'h9999; Mem_OE = 1'b1;
        step(1);
        Mem_OE = 1'b0;
        step(2);
        check("rd2_ready", Mem_Ready, 1);
        check("rd2_data", Data_to_CPU, 16'h1234);
        check("rd2_hex_keep", HEX_Data, 16'h00C5);
        step(1);

        // Held request produces a single access
        ready_cnt = 0;
        ADDR = 20'h00010; Mem_OE = 1'b1;
        step(5);
        Mem_OE = 1'b0;
        step(3);
        check("held_one_ready", ready_cnt, 1);
        Mem_OE = 1'b1;
        step(1);
        Mem_OE = 1'b0;
        check("repulse_rd_wait", SRAM_OE_N, 0);
        step(2);
        check("repulse_ready", Mem_Ready, 1);
        step(1);
        check("repulse_two_ready", ready_cnt, 2);

        // Simultaneous read and write edges: write wins
        ADDR = 20'h00020; Data_from_CPU = 16'hAAAA; Mem_OE = 1'b1; Mem_WE = 1'b1;
        step(1);
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        check("both_setup", {SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe}, 3'b111);
        step(3);
        check("both_hold_ready", Mem_Ready, 1);
        check("both_data_keep", Data_to_CPU, 16'h1234);
        step(1);
        ADDR = 20'h00020; Data_from_CPU = 16'h0000; Mem_OE = 1'b1;
        step(1);
        Mem_OE = 1'b0;
        step(2);
        check("both_readback", {Mem_Ready, Data_to_CPU}, {1'b1, 16'hAAAA});
        step(1);

        // Reset during the write pulse aborts the access
        ready_cnt = 0;
        ADDR = 20'h00030; Data_from_CPU = 16'h5555; Mem_WE = 1'b1;
        step(1);
        Mem_WE = 1'b0;
        step(1);
        check("abort_pulse_we", SRAM_WE_N, 0);
        Reset = 1'b1;
        step(1);
        check("abort_ctl", {SRAM_WE_N, SRAM_OE_N, SRAM_DQ_oe, Mem_Ready}, 4'b1100);
        check("abort_regs", {HEX_Data, Data_to_CPU}, 32'h0);
        Reset = 1'b0;
        step(4);
        check("abort_no_ready", ready_cnt, 0);

        // Request held across reset release counts as an edge
        Reset = 1'b1; ADDR = 20'h00020; Mem_OE = 1'b1;
        step(1);
        Reset = 1'b0;
        step(1);
        check("held_rst_rd_wait", SRAM_OE_N, 0);
        step(2);
        check("held_rst_ready", {Mem_Ready, Data_to_CPU}, {1'b1, 16'hAAAA});
        Mem_OE = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 datapath: accepts single-cycle-request read/write strobes from the instruction sequencer, runs a correctly timed cycle on the external asynchronous 16-bit SRAM, and returns a one-cycle completion pulse with read data. Address 0xFFFF is memory-mapped I/O: reads return the switches and writes load the hex-display register, with no SRAM cycle. Sits between the datapath's MAR/MDR and the board SRAM pins.

## Interface
- READ_WAIT, 2, cycles SRAM_OE_N held low before read data is sampled (>=1)
- WRITE_WAIT, 2, cycles SRAM_WE_N held low per write (>=1)
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- Mem_OE  in  1  read request, active-high; access starts on rising edge
- Mem_WE  in  1  write request, active-high; access starts on rising edge
- ADDR  in  20  word address (from MAR, zero-extended)
- Data_from_CPU  in  16  write data (from MDR)
- Data_to_CPU  out  16  registered read data
- Mem_Ready  out  1  one-cycle completion pulse
- Switches  in  16  board switches, returned for reads of 0xFFFF
- HEX_Data  out  16  display register, written at 0xFFFF
- SRAM_ADDR  out  20  SRAM address
- SRAM_DQ_in  in  16  SRAM data bus, input half
- SRAM_DQ_out  out  16  SRAM data bus, output half
- SRAM_DQ_oe  out  1  1 = drive SRAM_DQ_out onto bus
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls

## Operation
- States: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, IO_DONE.
- Request edge detect: rd_q/wr_q register Mem_OE/Mem_WE each cycle (reset 0); rd_edge = Mem_OE & ~rd_q, same for write. Edges are honoured only in IDLE; edges in other states are dropped.
- Simultaneous rd_edge and wr_edge: write performed, read ignored.
- IDLE: on an edge, latch ADDR into addr_r and Data_from_CPU into wdata_r. If addr_r would equal 0xFFFF -> IO_DONE (read: Data_to_CPU <= Switches; write: HEX_Data <= Data_from_CPU, both at the accepting edge). Else read -> RD_WAIT, write -> WR_SETUP.
- RD_WAIT: CE_N=0, OE_N=0, UB_N=LB_N=0, DQ_oe=0; wait counter runs READ_WAIT cycles; at the edge ending the last one, Data_to_CPU <= SRAM_DQ_in, -> RD_DONE.
- RD_DONE: Mem_Ready=1, SRAM controls inactive; -> IDLE.
- WR_SETUP (1 cycle): CE_N=0, WE_N=1, DQ_oe=1, UB_N=LB_N=0; -> WR_PULSE.
- WR_PULSE (WRITE_WAIT cycles): as WR_SETUP but WE_N=0; -> WR_HOLD.
- WR_HOLD (1 cycle): CE_N=0, WE_N=1, DQ_oe=1 (data hold), Mem_Ready=1; -> IDLE.
- IO_DONE: Mem_Ready=1; -> IDLE.
- SRAM_ADDR = addr_r and SRAM_DQ_out = wdata_r at all times; all SRAM control outputs and Mem_Ready are Moore-decoded from state.
- Wait counter width: clog2(max(READ_WAIT,WRITE_WAIT)+1); cleared on each state entry.
- Data_to_CPU holds its value until the next read completes; writes never change it.

## Timing
- Reset values (after the reset edge): state IDLE, Mem_Ready 0, Data_to_CPU 0x0000, HEX_Data 0x0000, addr_r 0, wdata_r 0, CE_N/OE_N/WE_N/UB_N/LB_N all 1, DQ_oe 0.
- Reset mid-access aborts immediately: WE_N/OE_N return high the cycle after the reset edge; no Mem_Ready is issued for the aborted access.
- Request held high across reset release: rd_q/wr_q are 0 after reset, so the held request counts as an edge in the first post-reset cycle.
- Edge accepted in cycle N: SRAM read -> Mem_Ready in cycle N+READ_WAIT+1 (default N+3), data valid the same cycle and after; SRAM write -> Mem_Ready in cycle N+WRITE_WAIT+2 (default N+4); I/O access -> Mem_Ready in N+1.
- Back-to-back: a new edge is accepted no earlier than the IDLE cycle following Mem_Ready; the requester must deassert and reassert.
- WE_N never falls in the same cycle DQ_oe rises, and never rises after DQ_oe falls.

## Test plan
- Write 0x1234 to 0x00010 then read it back: WE_N low for exactly 2 cycles between setup and hold; Mem_Ready at N+4 for the write; Data_to_CPU = 0x1234 with Mem_Ready at N+3 for the read.
- Switches=0xBEEF, read 0xFFFF: Mem_Ready at N+1, Data_to_CPU=0xBEEF, CE_N stays 1 throughout.
- Write 0x00C5 to 0xFFFF: HEX_Data=0x00C5 at N+1, no SRAM strobe; a subsequent SRAM read leaves HEX_Data unchanged.
- Mem_OE held high for 5 cycles: exactly one read and one Mem_Ready; re-pulsing Mem_OE starts a second read.
- Mem_OE and Mem_WE rise together at 0x00020, data 0xAAAA: a write occurs; a later read returns 0xAAAA.
- Reset asserted during WR_PULSE: WE_N=1, DQ_oe=0 the next cycle, no Mem_Ready, HEX_Data/Data_to_CPU = 0x0000.
